// File: rtl/rca32_arbiter_pkg.sv
// Shared types and sizes for the round-robin RCA32 arbiter.
package rca32_arb_pkg;

  localparam int WIDTH         = 32;
  localparam int CNT_W         = 16;
  localparam int N_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rca32_arbiter_if.sv
// Requester-side bus of the arbiter: packed per-requester operands and shared result.
interface rca32_arbiter_if
  import rca32_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
);

  logic [N_REQ-1:0]       req;
  logic [WIDTH*N_REQ-1:0] a_in;
  logic [WIDTH*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]       cin_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       sum_out;
  logic                   cout_out;
  logic                   busy;
  logic [CNT_W-1:0]       op_cnt;

  modport master (
    output req, a_in, b_in, cin_in,
    input  gnt, done, sum_out, cout_out, busy, op_cnt
  );

  modport slave (
    input  req, a_in, b_in, cin_in,
    output gnt, done, sum_out, cout_out, busy, op_cnt
  );

endinterface

// File: rtl/rca32.sv
// 32-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module RCA32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < 32; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/rca32_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above ptr, searching upward mod N_REQ.
module rca32_rr_pick
  import rca32_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand     = '0;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o         = 1'b1;
        idx_o           = cand;
        winner_o[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rca32_arbiter.sv
// Round-robin sequencer sharing one RCA32 among N_REQ requesters.
// IDLE picks and latches operands, ADD runs the adder, RESP pulses done.
module rca32_arbiter
  import rca32_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  rca32_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   pick_winner;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [WIDTH-1:0]   rca_sum;
  logic               rca_cout;

  rca32_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (pick_winner),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  RCA32 u_rca (
    .a_i    (a_q),
    .b_i    (b_q),
    .cin_i  (cin_q),
    .sum_o  (rca_sum),
    .cout_o (rca_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Operands are copied here so the requester may change them after grant.
        if (pick_valid) begin
          state_d = ADD;
          idx_d   = pick_idx;
          gnt_d   = pick_winner;
          a_d     = bus.a_in[int'(pick_idx)*WIDTH +: WIDTH];
          b_d     = bus.b_in[int'(pick_idx)*WIDTH +: WIDTH];
          cin_d   = bus.cin_in[pick_idx];
        end
      end
      ADD: begin
        sum_d   = rca_sum;
        cout_d  = rca_cout;
        state_d = RESP;
      end
      RESP: begin
        cnt_d   = cnt_q + 1'b1;
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = (state_q == RESP) ? gnt_q : '0;
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.op_cnt   = cnt_q;

endmodule

// File: tb/tb_rca32_arbiter.sv
// Self-checking bench for rca32_arbiter: vector table, directed corner sequences, random ops vs model.
module tb_rca32_arbiter;
  import rca32_arb_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rca32_arbiter_if #(.N_REQ(N)) bus();

  rca32_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;
  logic [31:0] la [N];
  logic [31:0] lb [N];
  logic        lc [N];

  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         cin;
    int           w;
    logic [31:0]  sum;
    logic         cout;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    la[i] = a; lb[i] = b; lc[i] = c;
    bus.a_in[32*i +: 32] = a;
    bus.b_in[32*i +: 32] = b;
    bus.cin_in[i]        = c;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = '0;
  endtask

  // Inputs must already be set during an IDLE cycle (called at its negedge).
  task automatic run_op(input int w, input logic [31:0] exp_sum, input logic exp_cout,
                        input bit drop, input bit chg, input logic [31:0] new_a);
    logic [N-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("gnt_add", bus.gnt, oh);
    check("busy_add", bus.busy, 1);
    check("done_add", bus.done, 0);
    if (chg) bus.a_in[32*w +: 32] = new_a;
    @(posedge clk); @(negedge clk);
    check("done_resp", bus.done, oh);
    check("sum_resp", bus.sum_out, exp_sum);
    check("cout_resp", bus.cout_out, exp_cout);
    check("gnt_resp", bus.gnt, oh);
    if (drop) bus.req[w] = 1'b0;
    m_ptr = (w + 1) % N;
    m_cnt = m_cnt + 16'd1;
    @(posedge clk); @(negedge clk);
    check("op_cnt", bus.op_cnt, m_cnt);
    check("busy_idle", bus.busy, 0);
    check("gnt_idle", bus.gnt, 0);
    check("done_idle", bus.done, 0);
  endtask

  initial begin
    logic [N-1:0] m_mask;
    logic [32:0]  full;
    int           w;

    tbl[0] = '{4'b0001, 32'h0000_0005, 32'h0000_0003, 1'b0, 0, 32'h0000_0008, 1'b0};
    tbl[1] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 32'h0000_0001, 1'b1};
    tbl[2] = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 1'b0};
    tbl[3] = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{4'b0110, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 32'h0000_0001, 1'b0};
    tbl[5] = '{4'b0011, 32'h1234_5678, 32'h8765_4321, 1'b0, 0, 32'h9999_9999, 1'b0};
    tbl[6] = '{4'b1001, 32'h8000_0000, 32'h8000_0000, 1'b0, 3, 32'h0000_0000, 1'b1};

    bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.cin_in = '0;
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum_out, 0);
    check("rst_cout", bus.cout_out, 0);
    check("rst_cnt", bus.op_cnt, 0);

    // vector table; other lanes carry junk so a wrong lane select shows
    for (int i = 0; i < 7; i++) begin
      randomize_lanes();
      set_lane(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].cin);
      bus.req = tbl[i].req;
      run_op(tbl[i].w, tbl[i].sum, tbl[i].cout, 1'b1, 1'b0, 32'h0);
    end
    bus.req = '0;

    // fairness: all four held
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 32'(i + 1), 32'(256 * (i + 1)), 1'b0);
    bus.req = '1;
    for (int k = 0; k < 5; k++)
      run_op(k % N, 32'(257 * ((k % N) + 1)), 1'b0, 1'b0, 1'b0, 32'h0);
    bus.req = '0;

    // pointer resumption
    do_reset();
    randomize_lanes();
    set_lane(2, 32'h0000_0100, 32'h0000_0020, 1'b0);
    bus.req = 4'b0100;
    run_op(2, 32'h0000_0120, 1'b0, 1'b1, 1'b0, 32'h0);
    set_lane(0, 32'hA000_0000, 32'h6000_0000, 1'b1);
    set_lane(2, 32'h0000_0003, 32'h0000_0004, 1'b0);
    bus.req = 4'b0101;
    run_op(0, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h0);
    run_op(2, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'h0);
    bus.req = '0;

    // operand change after grant
    set_lane(1, 32'h0000_0010, 32'h0000_0005, 1'b0);
    bus.req = 4'b0010;
    run_op(1, 32'h0000_0015, 1'b0, 1'b1, 1'b1, 32'h0000_0099);
    bus.req = '0;

    // reset during ADD
    do_reset();
    set_lane(0, 32'h5, 32'h3, 1'b0);
    bus.req = 4'b0001;
    @(posedge clk); @(negedge clk);
    check("abort_gnt_add", bus.gnt, 4'b0001);
    rst_n = 1'b0;
    bus.req = '0;
    @(posedge clk); @(negedge clk);
    check("abort_gnt", bus.gnt, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_cnt", bus.op_cnt, 0);
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = '0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("abort_done_after", bus.done, 0);
      check("abort_cnt_after", bus.op_cnt, 0);
    end

    // random ops against the model
    m_mask = '0;
    for (int op = 0; op < 80; op++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_mask[i]) begin
          set_lane(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 1) == 1) m_mask[i] = 1'b1;
        end
      end
      if (m_mask == '0) m_mask[$urandom_range(0, N - 1)] = 1'b1;
      bus.req = m_mask;
      w = model_pick(m_mask, m_ptr);
      full = {1'b0, la[w]} + {1'b0, lb[w]} + {32'b0, lc[w]};
      run_op(w, full[31:0], full[32], 1'b1, ($urandom_range(0, 3) == 0), $urandom);
      m_mask[w] = 1'b0;
    end
    bus.req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rca32_arbiter.md
# rca32_arbiter

Round-robin arbiter and sequencer that shares a single `RCA32` 32-bit ripple-carry adder among `N_REQ` requesters. It grants one requester at a time, registers its operands into the adder, captures the sum and carry, and returns them with a one-cycle `done` pulse. It sits between the lab's multi-source datapath blocks and the adder, so only one adder instance exists in the design.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `clk` input, 1: single clock, all state updates on the rising edge.
- `rst_n` input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req` input, `N_REQ`: request per requester, level-held until `done`.
- `a_in` input, 32·`N_REQ`: packed operand A; requester i uses bits [32i+31:32i].
- `b_in` input, 32·`N_REQ`: packed operand B, same packing as `a_in`.
- `cin_in` input, `N_REQ`: carry-in per requester.
- `gnt` output, `N_REQ`: one-hot grant, held from the ADD state through the RESP state.
- `done` output, `N_REQ`: one-cycle one-hot completion pulse.
- `sum_out` output, 32: result; valid while `done` is high, held until the next result.
- `cout_out` output, 1: carry-out, with the same validity as `sum_out`.
- `busy` output, 1: high when the state is not IDLE.
- `op_cnt` output, 16: count of completed operations; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - If `req` is not zero, pick the winner i by round-robin starting at pointer `ptr` and searching upward mod `N_REQ`.
  - Latch A, B and cin of requester i into the operand registers, set `gnt`=onehot(i), go to ADD.
  - If `req` is zero, stay in IDLE.
- ADD:
  - The operand registers drive `RCA32`.
  - At the end of the cycle, capture the sum and carry into the result registers and go to RESP.
- RESP:
  - `done[i]`=1.
  - Increment `op_cnt`.
  - Set `ptr` ← (i+1) mod `N_REQ`.
  - Clear `gnt` and go to IDLE.
- Operands are copied at grant, so a requester may change its operands after `gnt` rises without corrupting the in-flight add.
- `req` is sampled only in IDLE. If a requester still holds `req` in the IDLE cycle after its own `done`, that counts as a new request. Requesters must drop `req` on the edge ending their `done` cycle.
- Requests that arrive while `busy` wait. No request is ever lost while `req` is held.
- With simultaneous requests, the requester nearest to `ptr` at or above it wins. Within `N_REQ` operations every persistent requester is served.
- Arithmetic: `{cout_out,sum_out}` = A + B + cin, taken modulo 2^33. There are no overflow or sign flags.
- Reset values: state=IDLE, `ptr`=0, `gnt`=0, `done`=0, `sum_out`=0, `cout_out`=0, `busy`=0, `op_cnt`=0.
- If `rst_n` is low in ADD or RESP, the operation is aborted with no `done` pulse and `op_cnt` is not incremented.

## Timing
- Cycle T (IDLE): `req` sampled.
- Cycle T+1 (ADD): `gnt`, `busy` high.
- Cycle T+2 (RESP): `done[i]`, `sum_out` and `cout_out` valid.
- Cycle T+3 (IDLE): next arbitration.
- Latency from sampled request to `done` is 2 cycles. Throughput is one operation per 3 cycles.
- The adder path is operand register → `RCA32` → result register, one full cycle. The clock period must cover the 32-bit ripple.
- `done` is exactly one cycle wide and never asserts for two requesters in the same cycle.
- `op_cnt` updates at the end of the RESP cycle, so its new value is visible at T+3.

## Structure
- Shared package `rca32_arb_pkg`:
  - state enum {IDLE, ADD, RESP};
  - `WIDTH`=32;
  - `CNT_W`=16;
  - `N_REQ_DEFAULT`=4.
- Sub-module `rca32_rr_pick`: combinational, inputs `req` and `ptr`, outputs one-hot `winner` and its index.
- The arbiter instantiates `rca32_rr_pick` once and the existing `RCA32` once. There is no other adder in the block.

## Test plan
- Single request: after reset, `req`=0001, A=0x0000_0005, B=0x0000_0003, cin=0 → `gnt`=0001 at T+1; `done`=0001, `sum_out`=0x0000_0008, `cout_out`=0 at T+2; `op_cnt`=1.
- Carry/wrap: A=0xFFFF_FFFF, B=0x0000_0001, cin=1 → `sum_out`=0x0000_0001, `cout_out`=1.
- Fairness: all four `req` held high → `done` order 0001, 0010, 0100, 1000, 0001, with a `done` every 3 cycles.
- Pointer resumption: serve requester 2 alone, then raise `req`=0101 → requester 0 is served first only if `ptr` wrapped; here `ptr`=3, so 0 wins, then 2.
- Operand change after grant: on requester 1, change A from 0x10 to 0x99 in the ADD cycle → `sum_out` uses 0x10.
- Reset mid-op: assert `rst_n`=0 during ADD → next cycle `gnt`=0, `busy`=0, no `done`, `op_cnt` unchanged at 0.
